// File: rtl/aib_avmm_redund_csr.sv
// aib_avmm_redund_csr: double-buffered AVMM CSR bank for AIB redundancy words
module aib_avmm_redund_csr #(
   parameter int                NUM_REG   = 4,
   parameter int                ADDR_W    = 7,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 7'h1c,
   parameter logic [ADDR_W-1:0] CTRL_ADDR = 7'h00,
   parameter logic [ADDR_W-1:0] STAT_ADDR = 7'h04,
   parameter logic [31:0]       RESET_VAL = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     address,
   input  logic [31:0]           writedata,
   input  logic [3:0]            byteenable,
   input  logic                  write,
   input  logic                  read,
   output logic [31:0]           readdata,
   output logic                  readdatavalid,
   output logic [NUM_REG*32-1:0] redund_out,
   output logic                  commit_done
);

   logic [31:0]        shadow [NUM_REG];
   logic [31:0]        active [NUM_REG];
   logic [ADDR_W-1:0]  off;
   logic [NUM_REG-1:0] sel;
   logic               reg_hit, ctrl_hit, stat_hit, unmapped;
   logic               auto_mode, lock, err_locked, err_unmapped;
   logic [7:0]         cnt;
   logic               wr_ok, ctrl_wr, commit;
   logic [31:0]        rd_reg, rd_mux;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b+:8] = be[b] ? d[8*b+:8] : old[8*b+:8];
      return r;
   endfunction

   // address decode: register window must be word-aligned inside the window
   always_comb begin
      off      = address - BASE_ADDR;
      reg_hit  = (address >= BASE_ADDR) && (32'(off) < 32'(4*NUM_REG)) && (off[1:0] == 2'b00);
      ctrl_hit = address == CTRL_ADDR;
      stat_hit = address == STAT_ADDR;
      unmapped = !(reg_hit || ctrl_hit || stat_hit);
      sel      = '0;
      rd_reg   = '0;
      for (int i = 0; i < NUM_REG; i++) begin
         sel[i] = reg_hit && (32'(off[ADDR_W-1:2]) == 32'(i));
         if (sel[i]) rd_reg = shadow[i];
      end
      rd_mux = reg_hit  ? rd_reg :
               ctrl_hit ? {29'd0, lock, auto_mode, 1'b0} :
               stat_hit ? {16'd0, cnt, 6'd0, err_unmapped, err_locked} : 32'd0;
      wr_ok   = write && !lock;
      ctrl_wr = wr_ok && ctrl_hit && byteenable[0];
      commit  = ctrl_wr && writedata[0];
   end

   // shadow writes, atomic commit to active, and AUTO write-through
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REG; i++) begin
            shadow[i] <= RESET_VAL;
            active[i] <= RESET_VAL;
         end
      end else begin
         for (int i = 0; i < NUM_REG; i++) begin
            if (wr_ok && sel[i]) shadow[i] <= merge(shadow[i], writedata, byteenable);
            if (commit) active[i] <= shadow[i];
            else if (wr_ok && sel[i] && auto_mode) active[i] <= merge(active[i], writedata, byteenable);
         end
      end
   end

   // control, sticky errors and commit counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         auto_mode    <= 1'b0;
         lock         <= 1'b0;
         err_locked   <= 1'b0;
         err_unmapped <= 1'b0;
         cnt          <= 8'd0;
         commit_done  <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            auto_mode <= writedata[1];
            lock      <= lock | writedata[2];
         end
         err_locked   <= (write && lock && (reg_hit || ctrl_hit)) ||
                         (err_locked && !(write && stat_hit && byteenable[0] && writedata[0]));
         err_unmapped <= ((write || read) && unmapped) ||
                         (err_unmapped && !(write && stat_hit && byteenable[0] && writedata[1]));
         cnt          <= commit ? cnt + 8'd1 : cnt;
         commit_done  <= commit;
      end
   end

   // registered read return; idle cycles return zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata      <= 32'd0;
         readdatavalid <= 1'b0;
      end else begin
         readdata      <= read ? rd_mux : 32'd0;
         readdatavalid <= read;
      end
   end

   for (genvar g = 0; g < NUM_REG; g++) begin : g_out
      assign redund_out[32*g+:32] = active[g];
   end

endmodule

// File: tb/tb_aib_avmm_redund_csr.sv
// tb_aib_avmm_redund_csr: directed checks of the redundancy CSR bank
module tb_aib_avmm_redund_csr;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [6:0]   address = '0;
   logic [31:0]  writedata = '0;
   logic [3:0]   byteenable = '0;
   logic         write = 1'b0;
   logic         read = 1'b0;
   logic [31:0]  readdata;
   logic         readdatavalid;
   logic [127:0] redund_out;
   logic         commit_done;
   int           vec = 0;
   int           miscmp = 0;
   int           hi = 0;
   logic [31:0]  rdata;
   logic         rvalid;

   aib_avmm_redund_csr dut (
      .clk(clk), .reset_n(reset_n), .address(address), .writedata(writedata),
      .byteenable(byteenable), .write(write), .read(read), .readdata(readdata),
      .readdatavalid(readdatavalid), .redund_out(redund_out), .commit_done(commit_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miscmp++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      address = a; writedata = d; byteenable = be; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic rd(input logic [6:0] a);
      @(negedge clk);
      address = a; read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      rdata = readdata;
      rvalid = readdatavalid;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      do_reset();
      chk("rst_out", redund_out[31:0] | redund_out[63:32] | redund_out[95:64] | redund_out[127:96], 32'h0);
      chk("rst_rdata", readdata, 32'h0);
      chk("rst_rvalid", {31'd0, readdatavalid}, 32'h0);
      rd(7'h04);
      chk("rst_stat", rdata, 32'h0);
      chk("rst_stat_valid", {31'd0, rvalid}, 32'h1);
      @(negedge clk);
      chk("idle_rvalid", {31'd0, readdatavalid}, 32'h0);

      wr(7'h20, 32'hA5A5_1234, 4'b0101);
      rd(7'h20);
      chk("reg1_shadow", rdata, 32'h00A5_0034);
      chk("reg1_out_pre", redund_out[63:32], 32'h0);
      wr(7'h00, 32'h1, 4'h1);
      chk("commit_out", redund_out[63:32], 32'h00A5_0034);
      chk("commit_done_hi", {31'd0, commit_done}, 32'h1);
      @(negedge clk);
      chk("commit_done_lo", {31'd0, commit_done}, 32'h0);
      rd(7'h04);
      chk("cnt1", rdata, 32'h0000_0100);

      wr(7'h00, 32'h2, 4'h1);
      chk("auto_no_commit", {31'd0, commit_done}, 32'h0);
      wr(7'h1c, 32'hDEAD_BEEF, 4'hF);
      chk("auto_out", redund_out[31:0], 32'hDEAD_BEEF);
      chk("auto_no_done", {31'd0, commit_done}, 32'h0);
      rd(7'h04);
      chk("auto_cnt", rdata, 32'h0000_0100);
      rd(7'h00);
      chk("ctrl_auto", rdata, 32'h2);

      wr(7'h00, 32'h4, 4'h1);
      wr(7'h24, 32'hFFFF_FFFF, 4'hF);
      wr(7'h00, 32'h1, 4'h1);
      chk("lock_no_commit", {31'd0, commit_done}, 32'h0);
      rd(7'h24);
      chk("lock_reg2", rdata, 32'h0);
      chk("lock_out2", redund_out[95:64], 32'h0);
      rd(7'h04);
      chk("lock_err", rdata, 32'h0000_0101);
      wr(7'h04, 32'h1, 4'h1);
      rd(7'h04);
      chk("err_clr", rdata, 32'h0000_0100);
      rd(7'h00);
      chk("lock_kept", rdata, 32'h4);

      rd(7'h7c);
      chk("unmap_rdata", rdata, 32'h0);
      chk("unmap_rvalid", {31'd0, rvalid}, 32'h1);
      rd(7'h04);
      chk("unmap_err", rdata, 32'h0000_0102);
      rd(7'h1e);
      chk("unaligned_rdata", rdata, 32'h0);

      do_reset();
      rd(7'h20);
      chk("rst2_shadow", rdata, 32'h0);
      chk("rst2_out", redund_out[63:32], 32'h0);
      rd(7'h04);
      chk("rst2_stat", rdata, 32'h0);

      wr(7'h1c, 32'h1234_5678, 4'hF);
      @(negedge clk);
      address = 7'h00; writedata = 32'h1; byteenable = 4'h1; write = 1'b1;
      for (int i = 1; i < 256; i++) begin
         @(negedge clk);
         if (commit_done) hi++;
      end
      @(negedge clk);
      write = 1'b0;
      chk("b2b_continuous", 32'(hi), 32'd255);
      chk("b2b_last_done", {31'd0, commit_done}, 32'h1);
      chk("b2b_out", redund_out[31:0], 32'h1234_5678);
      @(negedge clk);
      chk("b2b_done_lo", {31'd0, commit_done}, 32'h0);
      rd(7'h04);
      chk("cnt_wrap", rdata, 32'h0);

      @(negedge clk);
      address = 7'h28; writedata = 32'h1111_1111; byteenable = 4'hF; write = 1'b1; read = 1'b1;
      @(negedge clk);
      write = 1'b0; read = 1'b0;
      chk("rw_old", readdata, 32'h0);
      chk("rw_valid", {31'd0, readdatavalid}, 32'h1);
      rd(7'h28);
      chk("rw_new", rdata, 32'h1111_1111);
      chk("reg3_out_pre", redund_out[127:96], 32'h0);

      wr(7'h00, 32'h3, 4'h1);
      chk("commit_auto_out", redund_out[127:96], 32'h1111_1111);
      chk("commit_auto_done", {31'd0, commit_done}, 32'h1);
      wr(7'h28, 32'h2222_0000, 4'b1100);
      chk("auto_lanes", redund_out[127:96], 32'h2222_1111);
      rd(7'h04);
      chk("cnt_after", rdata, 32'h0000_0100);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
